// File: rtl/pixel_blend_reader_if.sv
// rtl/pixel_blend_reader_if.sv - control, memory read and pixel stream bundle for pixel_blend_reader
interface pixel_blend_reader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [8:0]        alpha;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        memory_out1;
  logic [7:0]        memory_out2;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    input  start, alpha, memory_out1, memory_out2, pix_ready,
    output busy, done, mem_addr, mem_rd_en, pix_out, pix_valid, sof, eol, eof
  );

  modport slave (
    output start, alpha, memory_out1, memory_out2, pix_ready,
    input  busy, done, mem_addr, mem_rd_en, pix_out, pix_valid, sof, eol, eof
  );
endinterface

// File: rtl/pixel_blend_reader.sv
// rtl/pixel_blend_reader.sv - raster reader of two images, alpha blend, valid/ready pixel stream out
module pixel_blend_reader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_blend_reader_if.master bus
);

  localparam int PW    = $clog2(FIFO_D);
  localparam int CW    = PW + 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW:0]       CREDITS   = (CW + 1)'(FIFO_D);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [8:0]        alpha_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

  // tag layout: {valid, sof, eol, eof}
  logic [3:0]        tag_q [RD_LAT];
  logic [10:0]       fifo_mem [FIFO_D];

  logic [CW:0]       credit_sum;
  logic              rd_en;
  logic              last_rd;
  logic              start_ok;
  logic [3:0]        iss_tag;
  logic [3:0]        ret_tag;
  logic              wr;
  logic              fire;
  logic              pix_valid;
  logic [10:0]       head;
  logic [8:0]        alpha_sat;
  logic [16:0]       sum;
  logic [7:0]        blend;

  assign start_ok   = (state_q == S_IDLE) && bus.start;
  assign alpha_sat  = (bus.alpha > 9'd256) ? 9'd256 : bus.alpha;

  // Credits cover both buffered pixels and reads still in the memory pipe,
  // so every returning pixel is guaranteed a FIFO slot.
  assign credit_sum = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign rd_en      = (state_q == S_RUN) && (credit_sum < CREDITS);
  assign last_rd    = rd_en && (addr_q == ADDR_LAST);
  assign iss_tag    = {1'b1, addr_q == '0, col_q == COL_LAST,
                       (row_q == ROW_LAST) && (col_q == COL_LAST)};

  assign ret_tag    = tag_q[RD_LAT-1];
  assign wr         = ret_tag[3];

  assign sum   = 17'(alpha_q) * 17'(bus.memory_out1)
               + (17'd256 - 17'(alpha_q)) * 17'(bus.memory_out2);
  assign blend = 8'(sum >> 8);

  assign pix_valid = (fifo_cnt_q != '0);
  assign head      = fifo_mem[rd_ptr_q];
  assign fire      = pix_valid && bus.pix_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_rd) state_d = S_DRAIN;
      S_DRAIN: if (fire && head[8] && (inflight_q == '0) && (fifo_cnt_q == CW'(1)))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en && !wr)
      inflight_d = inflight_q + CW'(1);
    else if (!rd_en && wr)
      inflight_d = inflight_q - CW'(1);
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (wr && !fire)
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!wr && fire)
      fifo_cnt_d = fifo_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alpha_q    <= '0;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (wr)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fire)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      if (start_ok) begin
        alpha_q <= alpha_sat;
        addr_q  <= '0;
        col_q   <= '0;
        row_q   <= '0;
      end else if (rd_en) begin
        // The final address is held rather than stepped so it never wraps.
        if (!last_rd)
          addr_q <= addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q != ROW_LAST)
            row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= rd_en ? iss_tag : 4'b0000;
      for (int i = 1; i < RD_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      fifo_mem[wr_ptr_q] <= {ret_tag[2:0], blend};
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_out   = pix_valid ? head[7:0] : 8'h00;
  assign bus.sof       = pix_valid && head[10];
  assign bus.eol       = pix_valid && head[9];
  assign bus.eof       = pix_valid && head[8];
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: doc/pixel_blend_reader.md
Name: pixel_blend_reader

Overview:
- Downstream consumer of the dual-port external image memory.
- Generates raster read addresses and captures the two returned 8-bit pixels (image A on memory_out1, image B on memory_out2).
- Alpha-blends each pixel pair and emits the result as a valid/ready pixel stream with frame/line markers.
- Sits between the external memory model and the display/write-back stage.

Parameters:
- IMG_W, 256, pixels per line (>=2)
- IMG_H, 256, lines per frame (>=2)
- ADDR_W, 16, memory address width; IMG_W*IMG_H <= 2**ADDR_W
- RD_LAT, 1, cycles from mem_rd_en/mem_addr to valid memory_out1/2 (1..3)
- FIFO_D, 4, output FIFO depth (>= RD_LAT+2, power of 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- alpha  in  9  blend weight 0..256 for image A; sampled on accepted start
- mem_addr  out  ADDR_W  read address, raster order from 0
- mem_rd_en  out  1  read strobe
- memory_out1  in  8  image A pixel, RD_LAT cycles after the read
- memory_out2  in  8  image B pixel, same timing as memory_out1
- pix_out  out  8  blended pixel
- pix_valid  out  1  pix_out valid
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready
- sof  out  1  qualifies pix_out: first pixel of frame
- eol  out  1  qualifies pix_out: last pixel of line
- eof  out  1  qualifies pix_out: last pixel of frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel transfers

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0; FSM in IDLE; FIFO empty; in-flight pipeline cleared.
  - Reset mid-frame aborts the frame immediately; no done pulse.
- FSM states:
  - IDLE -> RUN on start; alpha is latched on this transition and busy goes high.
  - RUN -> DRAIN on the cycle the read of address IMG_W*IMG_H-1 issues.
  - DRAIN -> DONE when in-flight count is 0, FIFO is empty and the last pixel has transferred.
  - DONE -> IDLE after one cycle; done=1 and busy=0 in DONE.
  - start in any non-IDLE state is ignored.
- Read issue (RUN only):
  - mem_rd_en=1 when fifo_count + inflight_count < FIFO_D.
  - mem_addr increments by 1 per issued read; it holds when mem_rd_en=0.
  - No wrap within a frame; the address counter is reset to 0 on start.
- Return path:
  - An RD_LAT-deep shift register carries valid, sof, eol and eof tags alongside each read.
  - On a tag-valid cycle the blended pixel and its tags are written to the FIFO.
  - Credit accounting guarantees the FIFO never overflows; data returning from memory is never dropped.
- Tag generation, from column/row counters at read issue:
  - sof when address=0.
  - eol when col=IMG_W-1.
  - eof when address=IMG_W*IMG_H-1.
- Blend arithmetic:
  - sum = alpha*A + (256-alpha)*B, 17-bit unsigned; pix = sum[15:8], truncating.
  - alpha=256 -> pix=A; alpha=0 -> pix=B.
  - alpha>256 is saturated to 256 at latch time.
- Output:
  - pix_out, pix_valid and tags are driven from the FIFO head.
  - They must be held stable while pix_valid & !pix_ready.
  - Simultaneous FIFO write and read in one cycle is supported; count is unchanged.
- Latency and throughput:
  - start at cycle 0; first mem_rd_en at cycle 1; first pix_valid at cycle 2+RD_LAT.
  - With pix_ready held high: 1 pixel/cycle sustained; done at cycle IMG_W*IMG_H+RD_LAT+2.
- Backpressure: with pix_ready low, reads stop after FIFO_D outstanding+buffered pixels and resume one cycle after a transfer frees a slot.

Test Plan:
- Reset/idle: hold rst_n=0 then release, no start -> all outputs 0 for 50 cycles; mem_rd_en never asserted.
- Basic frame (IMG_W=4, IMG_H=2, RD_LAT=1, alpha=256, A=addr, B=0xFF, ready=1) -> pix_out 0..7 on cycles 3..10, sof with 0, eol with 3 and 7, eof with 7, done at cycle 11, busy low after.
- Blend math: A=0xC8, B=0x40, alpha=128 -> pix_out=0x84; alpha=0 -> 0x40; alpha=300 -> 0xC8.
- Backpressure: pix_ready=0 for 20 cycles mid-frame -> at most FIFO_D reads outstanding, pix_out held stable, no pixel lost or duplicated; the full 8-pixel sequence matches expected.
- Ignored start / RD_LAT=3: pulse start during RUN -> no restart and address sequence unchanged; with RD_LAT=3 first pix_valid is at cycle 5.
- Reset mid-frame: assert rst_n=0 after 3 pixels -> outputs 0 asynchronously; a new start then yields a complete frame from address 0 with sof on the first pixel.
